// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digits and decimal points from a multiplexed 4-digit 7-segment scan
module seg_scan_decoder #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [3:0]  an,
  input  logic [7:0]  cat,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err
);
  typedef enum logic [1:0] {WAIT, STAB, HELD} state_t;
  state_t      state_q, state_d;
  logic [3:0]  s_an_q, p_an_q;
  logic [7:0]  s_cat_q, p_cat_q;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] sh_val_q, sh_val_d, value_q, value_d;
  logic [3:0]  sh_dp_q, sh_dp_d, dp_q, dp_d;
  logic        fv_q, fv_d, se_q, se_d, ae_q, ae_d;
  logic        s_valid, s_inv, p_inv, changed, cap;
  logic [1:0]  idx;
  logic [4:0]  dec;

  function automatic logic one_zero(input logic [3:0] a);
    logic [3:0] z;
    z = ~a;
    return z != 4'h0 && (z & (z - 4'h1)) == 4'h0;
  endfunction

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign s_valid = one_zero(s_an_q);
  assign s_inv   = !s_valid && s_an_q != 4'hF;
  assign p_inv   = !one_zero(p_an_q) && p_an_q != 4'hF;
  assign changed = s_an_q != p_an_q || s_cat_q != p_cat_q;
  assign cnt_inc = (cnt_q >= 8'(SETTLE)) ? 8'(SETTLE) : cnt_q + 8'd1;
  assign idx     = !s_an_q[0] ? 2'd0 : !s_an_q[1] ? 2'd1 : !s_an_q[2] ? 2'd2 : 2'd3;
  assign dec     = decode(~s_cat_q[6:0]);

  // register the raw scan once and keep the previous sample for change detection
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      s_an_q  <= 4'hF;
      s_cat_q <= 8'hFF;
      p_an_q  <= 4'hF;
      p_cat_q <= 8'hFF;
    end else begin
      s_an_q  <= an;
      s_cat_q <= cat;
      p_an_q  <= s_an_q;
      p_cat_q <= s_cat_q;
    end
  end

  // settle FSM state and saturating stability counter
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= WAIT;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: a digit is captured once per run of SETTLE identical valid samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      WAIT: begin
        state_d = s_valid ? STAB : WAIT;
        cnt_d   = s_valid ? 8'd1 : 8'd0;
      end
      STAB: begin
        if (!s_valid) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end else if (changed) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == 8'(SETTLE)) begin
            cap     = 1'b1;
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (changed) begin
          state_d = s_valid ? STAB : WAIT;
          cnt_d   = s_valid ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // shadow frame, publication and error pulses
  always_comb begin
    seen_d   = seen_q;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    value_d  = value_q;
    dp_d     = dp_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    ae_d     = s_inv && !p_inv;
    if (seen_q == 4'hF) begin
      value_d = sh_val_q;
      dp_d    = sh_dp_q;
      fv_d    = 1'b1;
      seen_d  = 4'h0;
    end
    if (cap) begin
      seen_d[idx]                 = 1'b1;
      sh_val_d[{idx, 2'b00} +: 4] = dec[3:0];
      sh_dp_d[idx]                = ~s_cat_q[7];
      se_d                        = !dec[4];
    end
  end

  // frame and output registers
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      seen_q   <= 4'h0;
      sh_val_q <= 16'h0;
      sh_dp_q  <= 4'h0;
      value_q  <= 16'h0;
      dp_q     <= 4'h0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
      ae_q     <= 1'b0;
    end else begin
      seen_q   <= seen_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
      ae_q     <= ae_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign frame_valid = fv_q;
  assign seg_err     = se_q;
  assign an_err      = ae_q;
endmodule
